// File: rtl/rv64_pkg.sv
// Shared RV64I pipeline definitions.
// Opcodes, load size codes and write-back FSM states.
package rv64_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: shift the doubleword down to the
// addressed byte, then sign- or zero-extend by access size.
module load_align
  import rv64_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [63:0] data,
  output logic        illegal
);

  logic [63:0] sh;

  assign sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (func3)
      F3_LB:   data = {{56{sh[7]}}, sh[7:0]};
      F3_LH:   data = {{48{sh[15]}}, sh[15:0]};
      F3_LW:   data = {{32{sh[31]}}, sh[31:0]};
      F3_LD:   data = sh;
      F3_LBU:  data = {56'd0, sh[7:0]};
      F3_LHU:  data = {48'd0, sh[15:0]};
      F3_LWU:  data = {32'd0, sh[31:0]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV64I write-back stage: result select, load wait and
// alignment, register-file write port toward decode.
module wb_stage
  import rv64_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_func3,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [2:0]      in_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [6:0]      wb_opcode,
  output logic            retire,
  output logic            stall
);

  wb_state_t state, state_nx;

  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [2:0]      ld_off;
  logic [6:0]      ld_opc;
  logic [XLEN-1:0] ld_data;
  logic            ld_ill;
  logic            accept;
  logic            is_load;
  logic            res_we;
  logic [XLEN-1:0] res_data;

  assign accept  = in_valid & in_ready;
  assign is_load = (in_opcode == OPC_LOAD);

  load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (ld_off),
    .func3   (ld_f3),
    .data    (ld_data),
    .illegal (ld_ill)
  );

  always_comb begin
    res_we   = 1'b1;
    res_data = '0;
    case (in_opcode)
      OPC_JAL, OPC_JALR:   res_data = in_pc4;
      OPC_OPW, OPC_OPIMMW: res_data = {{32{in_alu[31]}}, in_alu[31:0]};
      OPC_OP, OPC_OPIMM,
      OPC_LUI, OPC_AUIPC:  res_data = in_alu;
      default:             res_we   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WB_IDLE:      if (accept && is_load) state_nx = WB_WAIT_LOAD;
      WB_WAIT_LOAD: if (mem_rvalid)        state_nx = WB_IDLE;
      default:                             state_nx = WB_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == WB_IDLE);
    stall    = (state == WB_WAIT_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en     <= 1'b0;
      retire    <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_opcode <= '0;
      ld_rd     <= '0;
      ld_f3     <= '0;
      ld_off    <= '0;
      ld_opc    <= '0;
    end else begin
      wb_en  <= 1'b0;
      retire <= 1'b0;
      if (state == WB_IDLE && accept) begin
        if (is_load) begin
          ld_rd  <= in_rd;
          ld_f3  <= in_func3;
          ld_off <= in_addr_lo;
          ld_opc <= in_opcode;
        end else begin
          wb_en     <= res_we && (in_rd != 5'd0);
          retire    <= 1'b1;
          wb_rd     <= in_rd;
          wb_data   <= res_data;
          wb_opcode <= in_opcode;
        end
      end else if (state == WB_WAIT_LOAD && mem_rvalid) begin
        wb_en     <= !ld_ill && (ld_rd != 5'd0);
        retire    <= 1'b1;
        wb_rd     <= ld_rd;
        wb_data   <= ld_ill ? '0 : ld_data;
        wb_opcode <= ld_opc;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table for
// non-load ops, hand sequences for loads and reset.
module tb_wb_stage;

  import rv64_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [4:0]  in_rd;
  logic [63:0] in_alu;
  logic [63:0] in_pc4;
  logic [2:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [6:0]  wb_opcode;
  logic        retire;
  logic        stall;

  wb_stage #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_func3   (in_func3),
    .in_rd      (in_rd),
    .in_alu     (in_alu),
    .in_pc4     (in_pc4),
    .in_addr_lo (in_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_opcode  (wb_opcode),
    .retire     (retire),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic        en;
    logic [63:0] data;
    logic        chk;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [6:0]  opc;
    logic        chk;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   en_pulses = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_en) en_pulses++;
      if (retire) begin
        if (q.size() == 0) begin
          check("unexpected_retire", 64'(retire), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wb_en", 64'(wb_en), 64'(e.en));
          check("wb_rd", 64'(wb_rd), 64'(e.rd));
          check("wb_opcode", 64'(wb_opcode), 64'(e.opc));
          if (e.chk) check("wb_data", wb_data, e.data);
        end
      end else if (wb_en) begin
        check("wb_en_without_retire", 64'(wb_en), 64'd0);
      end
    end
  end

  task automatic push(input logic en, input logic [4:0] rd,
                      input logic [63:0] d, input logic [6:0] opc,
                      input logic chk);
    exp_t e;
    e.en = en; e.rd = rd; e.data = d; e.opc = opc; e.chk = chk;
    q.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.opc;
    in_func3  = v.f3;
    in_rd     = v.rd;
    in_alu    = v.alu;
    in_pc4    = v.pc4;
    push(v.en, v.rd, v.data, v.opc, v.chk);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [2:0] off, input logic [63:0] rdata,
                         input int delay, input logic en,
                         input logic [63:0] exp);
    in_valid   = 1'b1;
    in_opcode  = OPC_LOAD;
    in_func3   = f3;
    in_rd      = rd;
    in_addr_lo = off;
    in_alu     = 64'h5A5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      check("load_stall", 64'(stall), 64'd1);
      check("load_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("load_stall_last", 64'(stall), 64'd1);
    push(en, rd, exp, OPC_LOAD, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("load_done_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{OPC_OP,     3'd0, 5'd5, 64'h1234, 64'h0, 1'b1, 64'h1234, 1'b1};
    vt[1] = '{OPC_OPW,    3'd0, 5'd3, 64'h0000_0000_8000_0000, 64'h0,
              1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vt[2] = '{OPC_OPIMMW, 3'd0, 5'd4, 64'hFFFF_FFFF_0000_7FFF, 64'h0,
              1'b1, 64'h0000_0000_0000_7FFF, 1'b1};
    vt[3] = '{OPC_STORE,  3'd2, 5'd9, 64'h100, 64'h0, 1'b0, 64'h0, 1'b0};
    vt[4] = '{OPC_BRANCH, 3'd0, 5'd2, 64'h1, 64'h0, 1'b0, 64'h0, 1'b0};
    vt[5] = '{OPC_OP,     3'd0, 5'd0, 64'h55, 64'h0, 1'b0, 64'h0, 1'b0};
    vt[6] = '{OPC_JAL,    3'd0, 5'd1, 64'h99, 64'h1004, 1'b1, 64'h1004, 1'b1};
    vt[7] = '{OPC_JALR,   3'd0, 5'd2, 64'h77, 64'h2008, 1'b1, 64'h2008, 1'b1};
    vt[8] = '{OPC_LUI,    3'd0, 5'd6, 64'hFFFF_FFFF_DEAD_0000, 64'h0,
              1'b1, 64'hFFFF_FFFF_DEAD_0000, 1'b1};
    vt[9] = '{7'h7F,      3'd0, 5'd8, 64'h1, 64'h0, 1'b0, 64'h0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_func3 = '0;
    in_rd = '0; in_alu = '0; in_pc4 = '0; in_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_opcode", 64'(wb_opcode), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i]);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end

    en_pulses = 0;
    for (int i = 0; i < 3; i++)
      drive('{OPC_OPIMM, 3'd0, 5'(10 + i), 64'(100 + i), 64'h0,
              1'b1, 64'(100 + i), 1'b1});
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_pulses", 64'(en_pulses), 64'd3);

    do_load(F3_LB,  5'd7,  3'd3, 64'h0000_0000_80FF_0000, 2,
            1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    do_load(F3_LHU, 5'd8,  3'd6, 64'hBEEF_0000_0000_0000, 0,
            1'b1, 64'h0000_0000_0000_BEEF);
    do_load(F3_LW,  5'd9,  3'd4, 64'h8765_4321_0000_0000, 1,
            1'b1, 64'hFFFF_FFFF_8765_4321);
    do_load(F3_LD,  5'd10, 3'd0, 64'h0123_4567_89AB_CDEF, 0,
            1'b1, 64'h0123_4567_89AB_CDEF);
    do_load(F3_LWU, 5'd11, 3'd0, 64'h0000_0000_F000_0001, 0,
            1'b1, 64'h0000_0000_F000_0001);
    do_load(3'b111, 5'd12, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0,
            1'b0, 64'h0);
    do_load(F3_LB,  5'd0,  3'd0, 64'h12, 0, 1'b0, 64'h12);

    en_pulses = 0;
    in_valid = 1'b1; in_opcode = OPC_LOAD; in_func3 = F3_LD;
    in_rd = 5'd13; in_addr_lo = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rvalid_idle_ready", 64'(in_ready), 64'd1);
    check("rvalid_idle_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("rst_load_no_write", 64'(en_pulses), 64'd0);
    check("rst_load_wb_en", 64'(wb_en), 64'd0);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
